// File: rtl/stream_mux2_if.sv
// Handshake bundle for the 2:1 stream merger: two producer ports (A, B) and one consumer port.
// The merger attaches through "master"; the producer/consumer environment uses "slave".
interface stream_mux2_if #(parameter int WIDTH = 16);
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] a_data;
   logic             a_last;
   logic             b_valid;
   logic             b_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_sel;
   logic             busy;

   modport master (
      input  a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
      output a_ready, b_ready, out_valid, out_data, out_last, out_sel, busy
   );

   modport slave (
      output a_valid, a_data, a_last, b_valid, b_data, b_last, out_ready,
      input  a_ready, b_ready, out_valid, out_data, out_last, out_sel, busy
   );
endinterface

// File: rtl/stream_mux2.sv
// Two-input round-robin stream merger with optional packet lock and a registered output stage.
module stream_mux2 #(
   parameter int WIDTH = 16,
   parameter bit LOCK  = 1'b1
) (
   input logic          clk,
   input logic          reset,
   stream_mux2_if.master s
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2} state_t;

   state_t           state, state_nxt;
   logic             last_winner;          // 0 = A, 1 = B
   logic             load, pick_a, pick_b, grant_a, grant_b;
   logic             a_rdy, b_rdy, xfer_a, xfer_b;
   logic             out_valid_q, out_last_q, out_sel_q;
   logic [WIDTH-1:0] out_data_q;

   always_comb begin
      load      = ~out_valid_q | s.out_ready;
      // On a tie the channel that did not win last time goes first.
      pick_a    = s.a_valid & (~s.b_valid | last_winner);
      pick_b    = s.b_valid & (~s.a_valid | ~last_winner);
      grant_a   = (state == GRANT_A) | ((state == IDLE) & pick_a);
      grant_b   = (state == GRANT_B) | ((state == IDLE) & pick_b);
      a_rdy     = ~reset & load & grant_a;
      b_rdy     = ~reset & load & grant_b;
      xfer_a    = s.a_valid & a_rdy;
      xfer_b    = s.b_valid & b_rdy;
      state_nxt = state;
      if (LOCK) begin
         if (xfer_a)      state_nxt = s.a_last ? IDLE : GRANT_A;
         else if (xfer_b) state_nxt = s.b_last ? IDLE : GRANT_B;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_winner <= 1'b1;
      end else begin
         state <= state_nxt;
         if (xfer_a | xfer_b) last_winner <= xfer_b;
      end
   end

   // Output register only moves when it is empty or being drained, so a stall holds it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_sel_q   <= 1'b0;
      end else if (load) begin
         out_valid_q <= xfer_a | xfer_b;
         if (xfer_a) begin
            out_data_q <= s.a_data;
            out_last_q <= s.a_last;
            out_sel_q  <= 1'b0;
         end else if (xfer_b) begin
            out_data_q <= s.b_data;
            out_last_q <= s.b_last;
            out_sel_q  <= 1'b1;
         end
      end
   end

   assign s.a_ready   = a_rdy;
   assign s.b_ready   = b_rdy;
   assign s.out_valid = out_valid_q;
   assign s.out_data  = out_data_q;
   assign s.out_last  = out_last_q;
   assign s.out_sel   = out_sel_q;
   assign s.busy      = (state != IDLE) | out_valid_q;

endmodule

// File: tb/tb_stream_mux2.sv
// Bench for stream_mux2: directed scenarios on a locked and an unlocked instance,
// then random traffic checked against a beat-level arbitration model.
module tb_stream_mux2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   stream_mux2_if #(.WIDTH(16)) ia ();
   stream_mux2_if #(.WIDTH(16)) ib ();

   stream_mux2 #(.WIDTH(16), .LOCK(1'b1)) u_lock   (.clk(clk), .reset(reset), .s(ia));
   stream_mux2 #(.WIDTH(16), .LOCK(1'b0)) u_nolock (.clk(clk), .reset(reset), .s(ib));

   task automatic idle_inputs();
      ia.a_valid = 0; ia.a_data = '0; ia.a_last = 0;
      ia.b_valid = 0; ia.b_data = '0; ia.b_last = 0; ia.out_ready = 1;
      ib.a_valid = 0; ib.a_data = '0; ib.a_last = 0;
      ib.b_valid = 0; ib.b_data = '0; ib.b_last = 0; ib.out_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      ia.a_valid = 1; ia.b_valid = 1; ib.a_valid = 1; ib.b_valid = 1;
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if ({ia.a_ready, ia.b_ready, ia.out_valid, ia.out_last, ia.out_sel, ia.busy} !== 6'b0 || ia.out_data !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_lock: rdy=%b%b vld=%b data=%h busy=%b, want all 0", ia.a_ready, ia.b_ready, ia.out_valid, ia.out_data, ia.busy);
         end
         n_cmp++;
         if ({ib.a_ready, ib.b_ready, ib.out_valid, ib.busy} !== 4'b0 || ib.out_data !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_nolock: rdy=%b%b vld=%b data=%h, want all 0", ib.a_ready, ib.b_ready, ib.out_valid, ib.out_data);
         end
      end
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_alternate();
      do_reset();
      ia.a_valid = 1; ia.a_last = 1; ia.a_data = 16'h1111;
      ia.b_valid = 1; ia.b_last = 1; ia.b_data = 16'h2222;
      @(negedge clk);
      n_cmp++;
      if ({ia.a_ready, ia.b_ready, ia.out_valid} !== 3'b100) begin
         n_bad++;
         $display("FAIL alt_first: a_rdy=%b b_rdy=%b vld=%b, want 1 0 0", ia.a_ready, ia.b_ready, ia.out_valid);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (ia.out_valid !== 1'b1 || ia.out_sel !== k[0] || ia.out_data !== (k[0] ? 16'h2222 : 16'h1111)) begin
            n_bad++;
            $display("FAIL alt_beat%0d: vld=%b sel=%b data=%h, want 1 %b %h", k, ia.out_valid, ia.out_sel, ia.out_data, k[0], k[0] ? 16'h2222 : 16'h1111);
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_lock_packet();
      do_reset();
      ia.b_valid = 1; ia.b_data = 16'h00BB; ia.b_last = 1;
      for (int i = 0; i < 3; i++) begin
         ia.a_valid = 1; ia.a_data = 16'h00A0 + 16'(i); ia.a_last = (i == 2);
         @(negedge clk);
         n_cmp++;
         if (ia.a_ready !== 1'b1 || ia.b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_rdy%0d: a_rdy=%b b_rdy=%b, want 1 0", i, ia.a_ready, ia.b_ready);
         end
         if (i > 0) begin
            n_cmp++;
            if (ia.out_valid !== 1'b1 || ia.out_sel !== 1'b0 || ia.out_data !== 16'h00A0 + 16'(i - 1)) begin
               n_bad++;
               $display("FAIL lock_out%0d: vld=%b sel=%b data=%h, want 1 0 %h", i - 1, ia.out_valid, ia.out_sel, ia.out_data, 16'h00A0 + 16'(i - 1));
            end
         end
         @(posedge clk); #1;
      end
      ia.a_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ia.out_data !== 16'h00A2 || ia.out_last !== 1'b1 || ia.b_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL lock_tail: data=%h last=%b b_rdy=%b, want 00a2 1 1", ia.out_data, ia.out_last, ia.b_ready);
      end
      @(posedge clk); #1;
      ia.b_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b1 || ia.out_sel !== 1'b1 || ia.out_data !== 16'h00BB) begin
         n_bad++;
         $display("FAIL lock_b: vld=%b sel=%b data=%h, want 1 1 00bb", ia.out_valid, ia.out_sel, ia.out_data);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_stall();
      logic [15:0] d0, d1;
      do_reset();
      d0 = 16'($urandom); d1 = ~d0;
      ia.a_valid = 1; ia.a_last = 1; ia.a_data = d0;
      @(negedge clk);
      n_cmp++;
      if (ia.a_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_acc0: a_rdy=%b, want 1", ia.a_ready);
      end
      @(posedge clk); #1;
      ia.out_ready = 0; ia.a_data = d1;
      ia.b_valid = 1; ia.b_last = 1; ia.b_data = 16'h5A5A;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (ia.out_valid !== 1'b1 || ia.out_data !== d0 || ia.out_sel !== 1'b0 || ia.a_ready !== 1'b0 || ia.b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: vld=%b data=%h sel=%b rdy=%b%b, want 1 %h 0 00", ia.out_valid, ia.out_data, ia.out_sel, ia.a_ready, ia.b_ready, d0);
         end
         @(posedge clk); #1;
      end
      ia.b_valid = 0;
      ia.out_ready = 1;
      @(negedge clk);
      n_cmp++;
      if (ia.a_ready !== 1'b1 || ia.out_data !== d0) begin
         n_bad++;
         $display("FAIL stall_release: a_rdy=%b data=%h, want 1 %h", ia.a_ready, ia.out_data, d0);
      end
      @(posedge clk); #1;
      ia.a_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b1 || ia.out_data !== d1) begin
         n_bad++;
         $display("FAIL stall_next: vld=%b data=%h, want 1 %h", ia.out_valid, ia.out_data, d1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_nodup: vld=%b, want 0", ia.out_valid);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      ia.a_valid = 1; ia.a_last = 0; ia.a_data = 16'h00A0;
      @(negedge clk);
      n_cmp++;
      if (ia.a_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_acc: a_rdy=%b, want 1", ia.a_ready);
      end
      @(posedge clk); #1;
      reset = 1; ia.a_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ia.a_ready !== 1'b0 || ia.b_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_rdy: rdy=%b%b, want 00", ia.a_ready, ia.b_ready);
      end
      @(posedge clk); #1;
      reset = 0;
      ia.b_valid = 1; ia.b_last = 1; ia.b_data = 16'h0005;
      @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b0 || ia.b_ready !== 1'b1 || ia.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_idle: vld=%b b_rdy=%b busy=%b, want 0 1 0", ia.out_valid, ia.b_ready, ia.busy);
      end
      @(posedge clk); #1;
      ia.b_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ia.out_valid !== 1'b1 || ia.out_sel !== 1'b1 || ia.out_data !== 16'h0005) begin
         n_bad++;
         $display("FAIL rmid_b: vld=%b sel=%b data=%h, want 1 1 0005", ia.out_valid, ia.out_sel, ia.out_data);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_nolock_interleave();
      logic [15:0] pa[$], pb[$], got[$], exp[$];
      bit          acc_a, acc_b;
      do_reset();
      pa = '{16'h00A0, 16'h00A1};
      pb = '{16'h00B0, 16'h00B1};
      exp = '{16'h00A0, 16'h00B0, 16'h00A1, 16'h00B1};
      for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
         ib.a_valid = (pa.size() != 0); ib.a_data = ib.a_valid ? pa[0] : 16'h0; ib.a_last = (pa.size() == 1);
         ib.b_valid = (pb.size() != 0); ib.b_data = ib.b_valid ? pb[0] : 16'h0; ib.b_last = (pb.size() == 1);
         @(negedge clk);
         if (ib.out_valid === 1'b1) got.push_back(ib.out_data);
         acc_a = ib.a_valid && ib.a_ready === 1'b1;
         acc_b = ib.b_valid && ib.b_ready === 1'b1;
         @(posedge clk); #1;
         if (acc_a) void'(pa.pop_front());
         if (acc_b) void'(pb.pop_front());
      end
      n_cmp++;
      if (got.size() != 4) begin
         n_bad++;
         $display("FAIL nolock_count: got %0d beats, want 4", got.size());
      end
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin
               n_bad++;
               $display("FAIL nolock_beat%0d: data=%h, want %h", i, got[i], exp[i]);
            end
         end
      end
      idle_inputs();
   endtask

   // Model: who owns the port (locked channel or none), who won last, and the one beat held on the output.
   task automatic test_random();
      int          owner[2];
      bit          lw[2], hold[2];
      logic [15:0] hdata[2];
      bit          hlast[2], hsel[2];
      bit          av, bv, al, bl, ordy, cap, ea, eb;
      logic [15:0] ad, bd;
      int          who;
      bit          ar, br, ov, osel, olast, obusy;
      logic [15:0] odata;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         owner[d] = -1; lw[d] = 1; hold[d] = 0; hdata[d] = '0; hlast[d] = 0; hsel[d] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         av = ($urandom_range(9) < 7); bv = ($urandom_range(9) < 7);
         al = ($urandom_range(9) < 3); bl = ($urandom_range(9) < 3);
         ad = 16'($urandom); bd = 16'($urandom);
         ordy = ($urandom_range(9) < 7);
         ia.a_valid = av; ia.a_data = ad; ia.a_last = al; ia.b_valid = bv; ia.b_data = bd; ia.b_last = bl; ia.out_ready = ordy;
         ib.a_valid = av; ib.a_data = ad; ib.a_last = al; ib.b_valid = bv; ib.b_data = bd; ib.b_last = bl; ib.out_ready = ordy;
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            ar = d ? ib.a_ready : ia.a_ready;  br = d ? ib.b_ready : ia.b_ready;
            ov = d ? ib.out_valid : ia.out_valid; odata = d ? ib.out_data : ia.out_data;
            osel = d ? ib.out_sel : ia.out_sel; olast = d ? ib.out_last : ia.out_last;
            obusy = d ? ib.busy : ia.busy;
            cap = !hold[d] || ordy;
            if (owner[d] >= 0)  who = owner[d];
            else if (av && bv)  who = lw[d] ? 0 : 1;
            else if (av)        who = 0;
            else if (bv)        who = 1;
            else                who = -1;
            ea = cap && who == 0;
            eb = cap && who == 1;
            n_cmp++;
            if (ar !== ea || br !== eb) begin
               n_bad++;
               $display("FAIL rand_rdy dut%0d cyc%0d: rdy=%b%b, want %b%b", d, cyc, ar, br, ea, eb);
            end
            n_cmp++;
            if (ov !== hold[d] || obusy !== (hold[d] || owner[d] >= 0) ||
                (hold[d] && (odata !== hdata[d] || osel !== hsel[d] || olast !== hlast[d]))) begin
               n_bad++;
               $display("FAIL rand_out dut%0d cyc%0d: vld=%b data=%h sel=%b last=%b busy=%b, want %b %h %b %b %b",
                        d, cyc, ov, odata, osel, olast, obusy, hold[d], hdata[d], hsel[d], hlast[d], hold[d] || owner[d] >= 0);
            end
            if (hold[d] && ordy) hold[d] = 0;
            if ((av && ea) || (bv && eb)) begin
               hold[d]  = 1;
               hsel[d]  = !(av && ea);
               hdata[d] = hsel[d] ? bd : ad;
               hlast[d] = hsel[d] ? bl : al;
               lw[d]    = hsel[d];
               if (d == 0) owner[d] = hlast[d] ? -1 : int'(hsel[d]);
            end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alternate();
      test_lock_packet();
      test_stall();
      test_reset_mid_packet();
      test_nolock_interleave();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
